// File: rtl/sram_1rw1r_ctrl.sv
// Controller for a 1RW/1R SRAM macro: round-robin shares port 0 between A and B,
// port 1 serves read-only C, with registered macro commands and 2-cycle read return.
module sram_1rw1r_ctrl #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 8,
   parameter int WMASK_WIDTH = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   a_valid,
   output logic                   a_ready,
   input  logic                   a_we,
   input  logic [WMASK_WIDTH-1:0] a_wmask,
   input  logic [ADDR_WIDTH-1:0]  a_addr,
   input  logic [DATA_WIDTH-1:0]  a_wdata,
   output logic                   a_rvalid,
   output logic [DATA_WIDTH-1:0]  a_rdata,
   input  logic                   b_valid,
   output logic                   b_ready,
   input  logic                   b_we,
   input  logic [WMASK_WIDTH-1:0] b_wmask,
   input  logic [ADDR_WIDTH-1:0]  b_addr,
   input  logic [DATA_WIDTH-1:0]  b_wdata,
   output logic                   b_rvalid,
   output logic [DATA_WIDTH-1:0]  b_rdata,
   input  logic                   c_valid,
   output logic                   c_ready,
   input  logic [ADDR_WIDTH-1:0]  c_addr,
   output logic                   c_rvalid,
   output logic [DATA_WIDTH-1:0]  c_rdata,
   output logic                   sram_csb0,
   output logic                   sram_web0,
   output logic [WMASK_WIDTH-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0]  sram_addr0,
   output logic [DATA_WIDTH-1:0]  sram_din0,
   input  logic [DATA_WIDTH-1:0]  sram_dout0,
   output logic                   sram_csb1,
   output logic [ADDR_WIDTH-1:0]  sram_addr1,
   input  logic [DATA_WIDTH-1:0]  sram_dout1
);

   logic                   prio_b;  // 1: B wins the next tie
   logic                   gnt_a, gnt_b, acc_p0, acc_c, wr_hit;
   logic                   sel_we;
   logic [WMASK_WIDTH-1:0] sel_wmask;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;
   logic                   rd_vld_p0, rd_vld_p1, c_vld_p0, c_vld_p1;
   logic                   rd_id_p0, rd_id_p1;  // 0: A, 1: B

   always_comb begin
      gnt_a     = a_valid & (~b_valid | ~prio_b);
      gnt_b     = b_valid & (~a_valid |  prio_b);
      sel_we    = gnt_b ? b_we    : a_we;
      sel_wmask = gnt_b ? b_wmask : a_wmask;
      sel_addr  = gnt_b ? b_addr  : a_addr;
      sel_wdata = gnt_b ? b_wdata : a_wdata;
   end

   assign a_ready = rst_n & gnt_a;
   assign b_ready = rst_n & gnt_b;
   assign acc_p0  = a_ready | b_ready;
   // A port-1 read hitting the word port 0 is writing this cycle waits one cycle.
   assign wr_hit  = acc_p0 & sel_we & (sel_addr == c_addr);
   assign c_ready = rst_n & ~wr_hit;
   assign acc_c   = c_valid & c_ready;

   // ---- S0: issue registered commands to the macro ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_b      <= 1'b0;
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         sram_csb1   <= 1'b1;
         sram_addr1  <= '0;
         rd_vld_p0   <= 1'b0;
         c_vld_p0    <= 1'b0;
      end else begin
         sram_csb0 <= ~acc_p0;
         sram_web0 <= ~(acc_p0 & sel_we);
         if (acc_p0) begin
            sram_wmask0 <= sel_wmask;
            sram_addr0  <= sel_addr;
            sram_din0   <= sel_wdata;
            prio_b      <= gnt_a;
         end
         sram_csb1 <= ~acc_c;
         if (acc_c)
            sram_addr1 <= c_addr;
         rd_vld_p0 <= acc_p0 & ~sel_we;
         c_vld_p0  <= acc_c;
      end
   end

   always_ff @(posedge clk) begin
      rd_id_p0 <= gnt_b;
      rd_id_p1 <= rd_id_p0;
   end

   // ---- S1: macro captures the command and accesses the array ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld_p1 <= 1'b0;
         c_vld_p1  <= 1'b0;
      end else begin
         rd_vld_p1 <= rd_vld_p0;
         c_vld_p1  <= c_vld_p0;
      end
   end

   // ---- S2: sample macro read data and return it to the owner ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         c_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
         c_rdata  <= '0;
      end else begin
         a_rvalid <= rd_vld_p1 & ~rd_id_p1;
         b_rvalid <= rd_vld_p1 &  rd_id_p1;
         c_rvalid <= c_vld_p1;
         if (rd_vld_p1 & ~rd_id_p1)
            a_rdata <= sram_dout0;
         if (rd_vld_p1 & rd_id_p1)
            b_rdata <= sram_dout0;
         if (c_vld_p1)
            c_rdata <= sram_dout1;
      end
   end

endmodule
